// File: rtl/obi_axi_host_bridge_if.sv
// Bus bundles for the OBI-to-AXI-lite host bridge: the core-side OBI port and
// the single AXI-lite host slot driven by the bridge.

interface obi_core_if #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32
);
   logic                      data_req_i;
   logic                      data_gnt_o;
   logic                      data_we_i;
   logic [DataWidth/8-1:0]    data_be_i;
   logic [AddressWidth-1:0]   data_addr_i;
   logic [DataWidth-1:0]      data_wdata_i;
   logic                      data_rvalid_o;
   logic [DataWidth-1:0]      data_rdata_o;
   logic                      data_err_o;

   modport slave (
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );
   modport master (
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );
endinterface

interface axil_host_if #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32
);
   logic                      m_awvalid;
   logic                      m_awready;
   logic [AddressWidth-1:0]   m_awaddr;
   logic                      m_wvalid;
   logic                      m_wready;
   logic [DataWidth-1:0]      m_wdata;
   logic [DataWidth/8-1:0]    m_wstrb;
   logic                      m_bvalid;
   logic                      m_bready;
   logic                      m_arvalid;
   logic                      m_arready;
   logic [AddressWidth-1:0]   m_araddr;
   logic                      m_rvalid;
   logic                      m_rready;
   logic [DataWidth-1:0]      m_rdata;

   modport master (
      output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
             m_arvalid, m_araddr, m_rready,
      input  m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rdata
   );
   modport slave (
      input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
             m_arvalid, m_araddr, m_rready,
      output m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/obi_axi_host_bridge.sv
// Single-outstanding OBI load/store to AXI-lite host bridge with a per-transaction
// watchdog that converts a stalled handshake into an error response.
//
// state   | meaning
// IDLE    | waiting for a core request; grant is combinational
// WR_REQ  | AW and W offered, each until its own handshake
// WR_RESP | waiting for B
// RD_ADDR | AR offered
// RD_DATA | waiting for R

module obi_axi_host_bridge #(
   parameter int unsigned AddressWidth  = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   obi_core_if.slave       obi,
   axil_host_if.master     axi
);
   localparam int unsigned CntW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam int unsigned TcLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [AddressWidth-1:0] addr_q, addr_d;
   logic [DataWidth/8-1:0]  be_q, be_d;
   logic [DataWidth-1:0]    wdata_q, wdata_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    rvalid_q, rvalid_d;
   logic                    err_q, err_d;
   logic [DataWidth-1:0]    rdata_q, rdata_d;
   logic                    timeout;
   logic                    gnt, awvalid, wvalid, bready, arvalid, rready;
   logic                    aw_ok, w_ok;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;
      rdata_d   = '0;
      gnt       = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      aw_ok     = 1'b0;
      w_ok      = 1'b0;
      timeout   = (TimeoutCycles != 0) && (state_q != IDLE) && (cnt_q == CntW'(TcLast));

      if ((state_q != IDLE) && (TimeoutCycles != 0)) cnt_d = cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            gnt = obi.data_req_i;
            if (obi.data_req_i) begin
               addr_d    = obi.data_addr_i;
               be_d      = obi.data_be_i;
               wdata_d   = obi.data_wdata_i;
               cnt_d     = '0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = obi.data_we_i ? WR_REQ : RD_ADDR;
            end
         end
         WR_REQ: begin
            awvalid   = !aw_done_q;
            wvalid    = !w_done_q;
            aw_ok     = aw_done_q || axi.m_awready;
            w_ok      = w_done_q || axi.m_wready;
            aw_done_d = aw_ok;
            w_done_d  = w_ok;
            if (timeout) state_d = IDLE;
            else if (aw_ok && w_ok) state_d = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (axi.m_bvalid) begin
               state_d  = IDLE;
               rvalid_d = 1'b1;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (timeout) state_d = IDLE;
            else if (axi.m_arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (axi.m_rvalid) begin
               state_d  = IDLE;
               rvalid_d = 1'b1;
               rdata_d  = axi.m_rdata;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A completing handshake in the timeout cycle has already set rvalid_d.
      if (timeout && !rvalid_d) begin
         state_d  = IDLE;
         rvalid_d = 1'b1;
         err_d    = 1'b1;
      end
   end

   assign obi.data_gnt_o    = gnt;
   assign obi.data_rvalid_o = rvalid_q;
   assign obi.data_err_o    = err_q;
   assign obi.data_rdata_o  = rdata_q;

   assign axi.m_awvalid = awvalid;
   assign axi.m_awaddr  = addr_q;
   assign axi.m_wvalid  = wvalid;
   assign axi.m_wdata   = wdata_q;
   assign axi.m_wstrb   = be_q;
   assign axi.m_bready  = bready;
   assign axi.m_arvalid = arvalid;
   assign axi.m_araddr  = addr_q;
   assign axi.m_rready  = rready;

endmodule

// File: tb/tb_obi_axi_host_bridge.sv
// Directed bench for obi_axi_host_bridge: inputs driven 1 time unit after the
// rising edge, outputs sampled at the falling edge.

module tb_obi_axi_host_bridge;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   obi_core_if  #(.AddressWidth(AW), .DataWidth(DW)) obi ();
   axil_host_if #(.AddressWidth(AW), .DataWidth(DW)) axi ();

   obi_axi_host_bridge #(
      .AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(8)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .obi    (obi),
      .axi    (axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      obi.data_req_i   = 1'b0;
      obi.data_we_i    = 1'b0;
      obi.data_be_i    = '0;
      obi.data_addr_i  = '0;
      obi.data_wdata_i = '0;
      axi.m_awready    = 1'b0;
      axi.m_wready     = 1'b0;
      axi.m_bvalid     = 1'b0;
      axi.m_arready    = 1'b0;
      axi.m_rvalid     = 1'b0;
      axi.m_rdata      = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({obi.data_gnt_o, obi.data_rvalid_o, obi.data_err_o, axi.m_awvalid, axi.m_wvalid,
           axi.m_bready, axi.m_arvalid, axi.m_rready} !== 8'h00) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=00000000", {obi.data_gnt_o, obi.data_rvalid_o,
            obi.data_err_o, axi.m_awvalid, axi.m_wvalid, axi.m_bready, axi.m_arvalid, axi.m_rready});
      end
      total++;
      if ({axi.m_awaddr, axi.m_wdata, obi.data_rdata_o} !== 96'h0) begin
         bad++; $display("FAIL reset_data got=%h exp=0", {axi.m_awaddr, axi.m_wdata, obi.data_rdata_o});
      end
      next_cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      next_cyc();
      obi.data_req_i = 1'b1; obi.data_we_i = 1'b1; obi.data_be_i = 4'hF;
      obi.data_addr_i = 32'h0010_0008; obi.data_wdata_i = 32'h1234_5678;
      axi.m_awready = 1'b1; axi.m_wready = 1'b1;
      @(negedge clk);
      total++;
      if (obi.data_gnt_o !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%b exp=1", obi.data_gnt_o); end
      total++;
      if ({axi.m_awvalid, axi.m_wvalid} !== 2'b00) begin
         bad++; $display("FAIL wr_c0_valids got=%b exp=00", {axi.m_awvalid, axi.m_wvalid});
      end
      next_cyc();
      obi.data_req_i = 1'b0;
      @(negedge clk);
      total++;
      if ({axi.m_awvalid, axi.m_wvalid, obi.data_gnt_o} !== 3'b110) begin
         bad++; $display("FAIL wr_c1_valids got=%b exp=110", {axi.m_awvalid, axi.m_wvalid, obi.data_gnt_o});
      end
      total++;
      if ({axi.m_awaddr, axi.m_wdata, axi.m_wstrb} !== {32'h0010_0008, 32'h1234_5678, 4'hF}) begin
         bad++; $display("FAIL wr_c1_payload got=%h/%h/%h exp=00100008/12345678/f",
            axi.m_awaddr, axi.m_wdata, axi.m_wstrb);
      end
      next_cyc();
      axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b1;
      @(negedge clk);
      total++;
      if ({axi.m_bready, axi.m_awvalid, axi.m_wvalid, obi.data_rvalid_o} !== 4'b1000) begin
         bad++; $display("FAIL wr_c2 got=%b exp=1000", {axi.m_bready, axi.m_awvalid, axi.m_wvalid, obi.data_rvalid_o});
      end
      next_cyc();
      axi.m_bvalid = 1'b0;
      @(negedge clk);
      total++;
      if ({obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o, axi.m_bready} !== {2'b10, 32'h0, 1'b0}) begin
         bad++; $display("FAIL wr_resp got=%b/%b/%h/%b exp=1/0/0/0",
            obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o, axi.m_bready);
      end
      next_cyc();
      @(negedge clk);
      total++;
      if (obi.data_rvalid_o !== 1'b0) begin bad++; $display("FAIL wr_resp_pulse got=%b exp=0", obi.data_rvalid_o); end
   endtask

   task automatic test_split_write();
      int resp_cnt;
      resp_cnt = 0;
      next_cyc();
      obi.data_req_i = 1'b1; obi.data_we_i = 1'b1; obi.data_be_i = 4'h3;
      obi.data_addr_i = 32'h0000_0040; obi.data_wdata_i = 32'h1234_5678;
      @(negedge clk);
      next_cyc();
      obi.data_req_i = 1'b0; obi.data_wdata_i = 32'hDEAD_BEEF;
      axi.m_awready = 1'b1; axi.m_wready = 1'b0;
      @(negedge clk);
      total++;
      if ({axi.m_awvalid, axi.m_wvalid} !== 2'b11) begin
         bad++; $display("FAIL split_c1 got=%b exp=11", {axi.m_awvalid, axi.m_wvalid});
      end
      for (int i = 0; i < 2; i++) begin
         next_cyc();
         axi.m_awready = 1'b0;
         @(negedge clk);
         total++;
         if ({axi.m_awvalid, axi.m_wvalid, axi.m_wdata, axi.m_wstrb} !== {2'b01, 32'h1234_5678, 4'h3}) begin
            bad++; $display("FAIL split_hold%0d got=%b%b/%h/%h exp=01/12345678/3", i,
               axi.m_awvalid, axi.m_wvalid, axi.m_wdata, axi.m_wstrb);
         end
      end
      next_cyc();
      axi.m_wready = 1'b1;
      @(negedge clk);
      total++;
      if ({axi.m_awvalid, axi.m_wvalid, axi.m_bready} !== 3'b010) begin
         bad++; $display("FAIL split_wfire got=%b exp=010", {axi.m_awvalid, axi.m_wvalid, axi.m_bready});
      end
      next_cyc();
      axi.m_wready = 1'b0; axi.m_bvalid = 1'b1;
      @(negedge clk);
      total++;
      if ({axi.m_bready, axi.m_wvalid} !== 2'b10) begin
         bad++; $display("FAIL split_bready got=%b exp=10", {axi.m_bready, axi.m_wvalid});
      end
      next_cyc();
      axi.m_bvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (obi.data_rvalid_o === 1'b1) resp_cnt++;
         next_cyc();
      end
      total++;
      if (resp_cnt !== 1) begin bad++; $display("FAIL split_resp_count got=%0d exp=1", resp_cnt); end
   endtask

   task automatic test_read();
      next_cyc();
      obi.data_req_i = 1'b1; obi.data_we_i = 1'b0; obi.data_addr_i = 32'h0010_0008;
      axi.m_arready = 1'b1;
      @(negedge clk);
      total++;
      if ({obi.data_gnt_o, axi.m_arvalid} !== 2'b10) begin
         bad++; $display("FAIL rd_c0 got=%b exp=10", {obi.data_gnt_o, axi.m_arvalid});
      end
      next_cyc();
      obi.data_req_i = 1'b0;
      @(negedge clk);
      total++;
      if ({axi.m_arvalid, axi.m_araddr, axi.m_awvalid} !== {1'b1, 32'h0010_0008, 1'b0}) begin
         bad++; $display("FAIL rd_ar got=%b/%h exp=1/00100008", axi.m_arvalid, axi.m_araddr);
      end
      for (int i = 0; i < 2; i++) begin
         next_cyc();
         axi.m_arready = 1'b0;
         @(negedge clk);
         total++;
         if ({axi.m_arvalid, axi.m_rready, obi.data_rvalid_o} !== 3'b010) begin
            bad++; $display("FAIL rd_wait%0d got=%b exp=010", i, {axi.m_arvalid, axi.m_rready, obi.data_rvalid_o});
         end
      end
      next_cyc();
      axi.m_rvalid = 1'b1; axi.m_rdata = 32'h1234_5678;
      @(negedge clk);
      next_cyc();
      axi.m_rvalid = 1'b0; axi.m_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if ({obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o, axi.m_rready} !== {2'b10, 32'h1234_5678, 1'b0}) begin
         bad++; $display("FAIL rd_resp got=%b/%b/%h/%b exp=1/0/12345678/0",
            obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o, axi.m_rready);
      end
      next_cyc();
      @(negedge clk);
      total++;
      if ({obi.data_rvalid_o, obi.data_rdata_o} !== {1'b0, 32'h0}) begin
         bad++; $display("FAIL rd_resp_clear got=%b/%h exp=0/0", obi.data_rvalid_o, obi.data_rdata_o);
      end
   endtask

   task automatic test_timeout();
      next_cyc();
      obi.data_req_i = 1'b1; obi.data_we_i = 1'b0; obi.data_addr_i = 32'h0003_0000;
      axi.m_arready = 1'b0;
      @(negedge clk);
      next_cyc();
      obi.data_req_i = 1'b0;
      @(negedge clk);
      total++;
      if ({axi.m_arvalid, axi.m_araddr} !== {1'b1, 32'h0003_0000}) begin
         bad++; $display("FAIL to_c1 got=%b/%h exp=1/00030000", axi.m_arvalid, axi.m_araddr);
      end
      repeat (7) next_cyc();
      @(negedge clk);
      total++;
      if ({axi.m_arvalid, obi.data_rvalid_o} !== 2'b10) begin
         bad++; $display("FAIL to_c8 got=%b exp=10", {axi.m_arvalid, obi.data_rvalid_o});
      end
      next_cyc();
      obi.data_req_i = 1'b1; obi.data_we_i = 1'b0; obi.data_addr_i = 32'h0000_0010;
      axi.m_arready = 1'b1;
      @(negedge clk);
      total++;
      if ({axi.m_arvalid, obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o} !== {3'b011, 32'h0}) begin
         bad++; $display("FAIL to_resp got=%b%b%b/%h exp=011/0",
            axi.m_arvalid, obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o);
      end
      total++;
      if (obi.data_gnt_o !== 1'b1) begin bad++; $display("FAIL to_next_gnt got=%b exp=1", obi.data_gnt_o); end
      next_cyc();
      obi.data_req_i = 1'b0;
      @(negedge clk);
      total++;
      if ({axi.m_arvalid, axi.m_araddr} !== {1'b1, 32'h0000_0010}) begin
         bad++; $display("FAIL to_next_ar got=%b/%h exp=1/00000010", axi.m_arvalid, axi.m_araddr);
      end
      next_cyc();
      axi.m_arready = 1'b0; axi.m_rvalid = 1'b1; axi.m_rdata = 32'hA5A5_0001;
      @(negedge clk);
      next_cyc();
      axi.m_rvalid = 1'b0;
      @(negedge clk);
      total++;
      if ({obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o} !== {2'b10, 32'hA5A5_0001}) begin
         bad++; $display("FAIL to_next_resp got=%b%b/%h exp=10/a5a50001",
            obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o);
      end
   endtask

   task automatic test_back_to_back();
      next_cyc();
      obi.data_req_i = 1'b1; obi.data_we_i = 1'b1; obi.data_be_i = 4'hC;
      obi.data_addr_i = 32'h0000_0200; obi.data_wdata_i = 32'hCAFE_0000;
      axi.m_awready = 1'b1; axi.m_wready = 1'b1;
      @(negedge clk);
      next_cyc();
      obi.data_we_i = 1'b0; obi.data_addr_i = 32'h0000_0300;
      @(negedge clk);
      total++;
      if ({obi.data_gnt_o, axi.m_awvalid, axi.m_wvalid, axi.m_arvalid} !== 4'b0110) begin
         bad++; $display("FAIL b2b_c1 got=%b exp=0110", {obi.data_gnt_o, axi.m_awvalid, axi.m_wvalid, axi.m_arvalid});
      end
      next_cyc();
      axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b1;
      @(negedge clk);
      total++;
      if ({obi.data_gnt_o, axi.m_bready, axi.m_arvalid} !== 3'b010) begin
         bad++; $display("FAIL b2b_c2 got=%b exp=010", {obi.data_gnt_o, axi.m_bready, axi.m_arvalid});
      end
      next_cyc();
      axi.m_bvalid = 1'b0; axi.m_arready = 1'b1;
      @(negedge clk);
      total++;
      if ({obi.data_rvalid_o, obi.data_gnt_o, axi.m_awvalid, axi.m_wvalid, axi.m_arvalid} !== 5'b11000) begin
         bad++; $display("FAIL b2b_c3 got=%b exp=11000",
            {obi.data_rvalid_o, obi.data_gnt_o, axi.m_awvalid, axi.m_wvalid, axi.m_arvalid});
      end
      next_cyc();
      obi.data_req_i = 1'b0;
      @(negedge clk);
      total++;
      if ({axi.m_arvalid, axi.m_araddr, axi.m_awvalid, axi.m_wvalid} !== {1'b1, 32'h0000_0300, 2'b00}) begin
         bad++; $display("FAIL b2b_ar got=%b/%h/%b%b exp=1/00000300/00",
            axi.m_arvalid, axi.m_araddr, axi.m_awvalid, axi.m_wvalid);
      end
      next_cyc();
      axi.m_arready = 1'b0; axi.m_rvalid = 1'b1; axi.m_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      next_cyc();
      axi.m_rvalid = 1'b0;
      @(negedge clk);
      total++;
      if ({obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o} !== {2'b10, 32'h0BAD_F00D}) begin
         bad++; $display("FAIL b2b_rd_resp got=%b%b/%h exp=10/0badf00d",
            obi.data_rvalid_o, obi.data_err_o, obi.data_rdata_o);
      end
   endtask

   task automatic test_reset_mid();
      int late_resp;
      late_resp = 0;
      next_cyc();
      obi.data_req_i = 1'b1; obi.data_we_i = 1'b1; obi.data_be_i = 4'hF;
      obi.data_addr_i = 32'h0000_0500; obi.data_wdata_i = 32'h5555_AAAA;
      axi.m_awready = 1'b1; axi.m_wready = 1'b1;
      @(negedge clk);
      next_cyc();
      obi.data_req_i = 1'b0;
      @(negedge clk);
      next_cyc();
      axi.m_awready = 1'b0; axi.m_wready = 1'b0;
      @(negedge clk);
      total++;
      if (axi.m_bready !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", axi.m_bready); end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({obi.data_gnt_o, obi.data_rvalid_o, obi.data_err_o, axi.m_awvalid, axi.m_wvalid,
           axi.m_bready, axi.m_arvalid, axi.m_rready} !== 8'h00) begin
         bad++; $display("FAIL rst_mid_ctrl got=%b exp=00000000", {obi.data_gnt_o, obi.data_rvalid_o,
            obi.data_err_o, axi.m_awvalid, axi.m_wvalid, axi.m_bready, axi.m_arvalid, axi.m_rready});
      end
      total++;
      if ({axi.m_awaddr, axi.m_wdata, axi.m_wstrb} !== 68'h0) begin
         bad++; $display("FAIL rst_mid_data got=%h/%h/%h exp=0", axi.m_awaddr, axi.m_wdata, axi.m_wstrb);
      end
      next_cyc();
      rst_n = 1'b1;
      axi.m_bvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (obi.data_rvalid_o !== 1'b0 || axi.m_bready !== 1'b0) late_resp++;
         next_cyc();
         axi.m_bvalid = 1'b0;
      end
      total++;
      if (late_resp !== 0) begin bad++; $display("FAIL rst_mid_no_resp got=%0d exp=0", late_resp); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write();
      test_split_write();
      test_read();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
